// File: rtl/fwrisc_mem_arbiter.sv
// Arbitrates the FWRISC fetch (i*) and data (d*) ports onto one memory port.
// The winning command is held in registers until the memory acknowledges or the access times out.
module fwrisc_mem_arbiter #(
    parameter bit          FAIR    = 1'b1,
    parameter logic [15:0] TIMEOUT = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic        dready,
    output logic [31:0] drdata,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstb,
    output logic        mwrite,
    output logic        mvalid,
    input  logic [31:0] mrdata,
    input  logic        mready,
    output logic [1:0]  owner,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_I_BUSY = 2'b01,
        ST_D_BUSY = 2'b10
    } state_e;

    state_e      state_q;
    logic        last_d_q;
    logic [15:0] tcnt_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [3:0]  mwstb_q;
    logic        mwrite_q;
    logic        mvalid_q;
    logic [1:0]  owner_q;
    logic        err_q;

    logic grant_i_s;
    logic grant_d_s;
    logic done_s;
    logic arm_s;

    // Grant selection while idle: a lone requester wins, a tie goes by FAIR.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (ivalid && dvalid) begin
            if (FAIR) begin
                grant_d_s = ~last_d_q;
                grant_i_s = last_d_q;
            end else begin
                grant_d_s = 1'b1;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_i_s = ivalid;
            grant_d_s = dvalid;
        end
    end

    // err_q is raised one edge early so that it coincides with the aborting cycle.
    assign arm_s  = (TIMEOUT > 16'd1) && ((tcnt_q + 16'd1) == (TIMEOUT - 16'd1));
    assign done_s = mready || err_q;

    assign iready = (state_q == ST_I_BUSY) && done_s;
    assign dready = (state_q == ST_D_BUSY) && done_s;
    assign idata  = err_q ? 32'h0000_0000 : mrdata;
    assign drdata = err_q ? 32'h0000_0000 : mrdata;

    assign maddr  = maddr_q;
    assign mwdata = mwdata_q;
    assign mwstb  = mwstb_q;
    assign mwrite = mwrite_q;
    assign mvalid = mvalid_q;
    assign owner  = owner_q;
    assign err    = err_q;

    // Arbitration FSM with registered memory command, owner and error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            tcnt_q   <= 16'd0;
            maddr_q  <= 32'h0000_0000;
            mwdata_q <= 32'h0000_0000;
            mwstb_q  <= 4'h0;
            mwrite_q <= 1'b0;
            mvalid_q <= 1'b0;
            owner_q  <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tcnt_q <= 16'd0;
                    if (grant_i_s) begin
                        state_q  <= ST_I_BUSY;
                        last_d_q <= 1'b0;
                        maddr_q  <= iaddr;
                        mwdata_q <= 32'h0000_0000;
                        mwstb_q  <= 4'hF;
                        mwrite_q <= 1'b0;
                        mvalid_q <= 1'b1;
                        owner_q  <= 2'b01;
                        err_q    <= (TIMEOUT == 16'd1);
                    end else if (grant_d_s) begin
                        state_q  <= ST_D_BUSY;
                        last_d_q <= 1'b1;
                        maddr_q  <= daddr;
                        mwdata_q <= dwdata;
                        mwstb_q  <= dwstb;
                        mwrite_q <= dwrite;
                        mvalid_q <= 1'b1;
                        owner_q  <= 2'b10;
                        err_q    <= (TIMEOUT == 16'd1);
                    end else begin
                        mvalid_q <= 1'b0;
                        owner_q  <= 2'b00;
                        err_q    <= 1'b0;
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (done_s) begin
                        state_q  <= ST_IDLE;
                        tcnt_q   <= 16'd0;
                        mvalid_q <= 1'b0;
                        owner_q  <= 2'b00;
                        err_q    <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                        err_q  <= arm_s;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tcnt_q   <= 16'd0;
                    mvalid_q <= 1'b0;
                    owner_q  <= 2'b00;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Randomized bench for fwrisc_mem_arbiter (FAIR=1, TIMEOUT=8) against a
// cycle-level reference model built from the arbitration rules.
module tb_fwrisc_mem_arbiter;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic        dvalid;
    logic        dready;
    logic [31:0] drdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstb;
    logic        mwrite;
    logic        mvalid;
    logic [31:0] mrdata;
    logic        mready;
    logic [1:0]  owner;
    logic        err;

    fwrisc_mem_arbiter #(.FAIR(1'b1), .TIMEOUT(16'd8)) u_dut (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
        .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
        .dvalid(dvalid), .dready(dready), .drdata(drdata),
        .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
        .mvalid(mvalid), .mrdata(mrdata), .mready(mready),
        .owner(owner), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: 0 = nobody owns the memory, 1 = fetch, 2 = data
    int          m_owner;
    int          m_last;
    int          m_wait;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstb;
    logic        m_write;

    bit          i_ack;
    bit          d_ack;
    bit          granted;
    bit          rnd_en;
    int          launch_pct;
    int          mem_delay;
    logic [31:0] fix_rdata;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_wait  = 0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        granted = 1'b0;
    endtask

    task automatic model_step();
        bit tmo;
        bit ei;
        bit ed;
        tmo = (m_owner != 0) && (m_wait == TMO - 1);
        ei  = (m_owner == 1) && (mready || tmo);
        ed  = (m_owner == 2) && (mready || tmo);
        check_val("mvalid", 32'(mvalid), 32'(m_owner != 0));
        check_val("owner",  32'(owner),  32'(m_owner));
        check_val("err",    32'(err),    32'(tmo));
        check_val("iready", 32'(iready), 32'(ei));
        check_val("dready", 32'(dready), 32'(ed));
        if (m_owner != 0) begin
            check_val("maddr",  maddr,          m_addr);
            check_val("mwdata", mwdata,         m_wdata);
            check_val("mwstb",  32'(mwstb),     32'(m_wstb));
            check_val("mwrite", 32'(mwrite),    32'(m_write));
        end
        if (ei) check_val("idata",  idata,  tmo ? 32'h0 : mrdata);
        if (ed) check_val("drdata", drdata, tmo ? 32'h0 : mrdata);

        if (m_owner != 0) begin
            if (ei || ed) begin
                if (ei) i_ack = 1'b1;
                else    d_ack = 1'b1;
                m_owner = 0;
            end else begin
                m_wait++;
            end
        end else if (ivalid || dvalid) begin
            if (ivalid && dvalid) m_owner = (m_last == 1) ? 2 : 1;
            else                  m_owner = ivalid ? 1 : 2;
            m_last  = m_owner;
            m_wait  = 0;
            granted = 1'b1;
            if (m_owner == 1) begin
                m_addr = iaddr; m_wdata = 32'h0; m_wstb = 4'hF; m_write = 1'b0;
            end else begin
                m_addr = daddr; m_wdata = dwdata; m_wstb = dwstb; m_write = dwrite;
            end
        end
    endtask

    // requesters drop valid after their ready, then maybe issue a new request
    task automatic drive();
        if (i_ack) begin ivalid = 1'b0; i_ack = 1'b0; end
        if (d_ack) begin dvalid = 1'b0; d_ack = 1'b0; end
        if (rnd_en && !ivalid && ($urandom_range(0, 99) < launch_pct)) begin
            ivalid = 1'b1;
            iaddr  = $urandom & 32'hFFFF_FFFC;
        end
        if (rnd_en && !dvalid && ($urandom_range(0, 99) < launch_pct)) begin
            dvalid = 1'b1;
            daddr  = $urandom;
            dwdata = $urandom;
            dwstb  = 4'($urandom_range(0, 15));
            dwrite = 1'($urandom_range(0, 1));
        end
        if (granted && rnd_en)
            mem_delay = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
        granted = 1'b0;
        if (m_owner != 0) mready = (m_wait >= mem_delay);
        else              mready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mrdata = rnd_en ? $urandom : fix_rdata;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            @(negedge clock);
            model_step();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic i_start(input logic [31:0] a);
        i_ack = 1'b0; ivalid = 1'b1; iaddr = a;
    endtask

    task automatic d_start(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input logic wr);
        d_ack = 1'b0; dvalid = 1'b1; daddr = a; dwdata = w; dwstb = s; dwrite = wr;
    endtask

    initial begin
        reset = 1'b1;
        iaddr = 32'h0; ivalid = 1'b0; daddr = 32'h0; dwdata = 32'h0;
        dwstb = 4'h0; dwrite = 1'b0; dvalid = 1'b0; mrdata = 32'h0; mready = 1'b0;
        rnd_en = 1'b0; launch_pct = 0; mem_delay = 0; fix_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_mvalid", 32'(mvalid), 32'h0);
        check_val("rst_owner",  32'(owner),  32'h0);
        check_val("rst_err",    32'(err),    32'h0);
        check_val("rst_iready", 32'(iready), 32'h0);
        check_val("rst_dready", 32'(dready), 32'h0);
        check_val("rst_maddr",  maddr,       32'h0);
        check_val("rst_mwdata", mwdata,      32'h0);
        check_val("rst_mwstb",  32'(mwstb),  32'h0);
        check_val("rst_mwrite", 32'(mwrite), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // single fetch acknowledged in the first mvalid cycle
        fix_rdata = 32'h0000_0013; mem_delay = 0;
        i_start(32'h0000_0100);
        run(4);

        // load with five wait states
        fix_rdata = 32'h1234_5678; mem_delay = 5;
        d_start(32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 1'b0);
        run(10);

        // store that never gets mready: aborted by the timeout
        mem_delay = 1000;
        d_start(32'h0000_3000, 32'hCAFE_F00D, 4'hC, 1'b1);
        run(12);

        // both ports requesting back to back: grants must alternate
        rnd_en = 1'b1; launch_pct = 100;
        run(30);
        rnd_en = 1'b0; launch_pct = 0; mem_delay = 0;
        run(8);

        // reset in the middle of a data access
        mem_delay = 1000;
        d_start(32'h0000_4000, 32'h0BAD_F00D, 4'hF, 1'b1);
        run(3);
        mready = 1'b1;
        #1;
        check_val("pre_rst_dready", 32'(dready), 32'h1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_mvalid", 32'(mvalid), 32'h0);
        check_val("mid_rst_owner",  32'(owner),  32'h0);
        check_val("mid_rst_dready", 32'(dready), 32'h0);
        check_val("mid_rst_err",    32'(err),    32'h0);
        @(posedge clock);
        @(negedge clock);
        ivalid = 1'b0; dvalid = 1'b0; mready = 1'b0;
        model_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        fix_rdata = 32'h0000_0093; mem_delay = 0;
        i_start(32'h0000_0200);
        run(4);

        // random traffic, wait states and occasional timeouts
        rnd_en = 1'b1; launch_pct = 40;
        run(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwrisc_mem_arbiter.md
Name: fwrisc_mem_arbiter

Overview:
Shares one single-ported memory/bus interface between the FWRISC core's instruction-fetch port and its data port. The block sits between the fwrisc core (i*/d* valid-ready ports) and a unified memory or system-bus slave (m* port). It arbitrates each request, holds the winner's command stable in registers until the memory acknowledges, and routes the response and ready back to the owning requester.

Parameters:
- FAIR, 1: 1 = round-robin between I and D when both request. 0 = fixed priority, data wins.
- TIMEOUT, 0: 0 = no timeout. N>0 = cycles of mready low in a busy state before the access is aborted with err pulsed. Width is 16 bits.

Ports:
- clock  in  1  Core clock; all state changes on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- iaddr  in  32  Instruction fetch address.
- ivalid  in  1  Fetch request; held until iready.
- iready  out  1  Fetch complete; idata valid this cycle.
- idata  out  32  Fetch data (= mrdata).
- daddr  in  32  Data address.
- dwdata  in  32  Store data.
- dwstb  in  4  Byte strobes.
- dwrite  in  1  1 = store, 0 = load.
- dvalid  in  1  Data request; held until dready.
- dready  out  1  Data access complete.
- drdata  out  32  Load data (= mrdata).
- maddr  out  32  Registered address to memory.
- mwdata  out  32  Registered store data.
- mwstb  out  4  Registered strobes; 4'b1111 for fetches.
- mwrite  out  1  Registered write flag; 0 for fetches.
- mvalid  out  1  Memory request.
- mrdata  in  32  Memory read data.
- mready  in  1  Memory acknowledge.
- owner  out  2  Debug: 00 idle, 01 I, 10 D.
- err  out  1  One-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, mvalid=0, maddr/mwdata/mwstb/mwrite=0, iready=dready=0, owner=0, err=0, last_grant=I, timeout counter=0. Reset during an access abandons it silently; no ready is issued.
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE: sample ivalid/dvalid.
  - Only one valid: grant it.
  - Both valid, FAIR=0: grant D.
  - Both valid, FAIR=1: grant the port not in last_grant.
  - On grant, register the command: fetch gives maddr=iaddr, mwrite=0, mwstb=4'hF, mwdata=0; data gives the d* fields. Set last_grant and go to I_BUSY or D_BUSY. mvalid rises the next cycle.
- I_BUSY / D_BUSY: mvalid=1 and m* are stable.
  - When mready=1, the owner's ready=1 combinationally in the same cycle, with idata/drdata=mrdata. Next state is IDLE.
  - The non-owner's ready stays 0.
- One bubble cycle in IDLE between accesses is mandatory, so a requester's still-high valid in its completion cycle is never re-granted.
- Minimum latency is 2 cycles, valid to ready, when memory returns mready in the first mvalid cycle.
- idata and drdata both carry mrdata continuously. They are qualified only by iready/dready.
- Timeout (TIMEOUT>0):
  - The counter increments each busy cycle with mready=0 and clears on leaving busy.
  - When it reaches TIMEOUT: err=1 for one cycle, the owner's ready=1 with data forced to 32'h0, next state IDLE, mvalid drops.
- Requester deasserting valid while it owns the bus is a protocol violation. The access completes, and ready pulses and is ignored.
- mready while IDLE is ignored.
- Registered outputs: mvalid, m* command fields, owner, err. Combinational outputs: iready, dready, idata, drdata.

Test Plan:
- Single fetch: ivalid=1, iaddr=0x100, mready on first mvalid cycle, mrdata=0x00000013 -> mvalid high cycle 1 with maddr=0x100, mwrite=0, mwstb=F; iready=1 and idata=0x13 in cycle 1; owner returns to 00 in cycle 2.
- Store then fetch, FAIR=0, both valid at t0: daddr=0x2000, dwdata=0xDEADBEEF, dwstb=0x3, dwrite=1 -> D granted first, with m* showing those values. I is granted after the bubble; iready never coincides with dready.
- Round-robin, FAIR=1, both valid continuously for 4 accesses -> grant order I, D, I, D. last_grant toggles.
- Memory wait states: mready delayed 5 cycles -> maddr, mwdata and mwstb stay constant all 5 cycles; dready asserts only in the mready cycle; load returns mrdata=0x12345678 on drdata.
- Timeout, TIMEOUT=8, mready held 0 -> err pulses in the 8th busy cycle with dready=1 and drdata=0; FSM is IDLE the next cycle.
- Reset mid-access, in D_BUSY -> mvalid, owner and dready drop to 0 asynchronously. After release, a new ivalid is granted normally.
